mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Physical bus controller directly downstream of the MMU. It consumes the MMU's physical request (ce, address, data, we, 16-bit device select) and executes it on either the external 32-bit asynchronous SRAM or the 16-bit NOR flash. It returns read data and a single-cycle ack. Device timing is set by wait-state parameters.

Parameters:
SRAM_WAIT, 2, cycles the SRAM strobes stay asserted per access (legal range 1..15)
FLASH_WAIT, 4, cycles flash strobes stay asserted per 16-bit half access (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
bus_ce_i  in  1  request enable from MMU
bus_addr_i  in  32  physical byte address
bus_data_i  in  32  write data
bus_we_i  in  1  1 = write
bus_select_i  in  16  device select: bit0 SRAM, bit1 flash, other bits unmapped
bus_data_o  out  32  read data, registered
bus_ack_o  out  1  one-cycle completion pulse
sram_addr_o  out  20  SRAM word address = bus_addr_i[21:2]
sram_data_o  out  32  SRAM write data
sram_data_i  in  32  SRAM read data
sram_data_oe  out  1  1 = drive the SRAM data bus
sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM strobes, active-low
sram_be_n  out  4  byte enables, active-low; always 4'b0000 during an access
flash_addr_o  out  23  flash halfword address
flash_data_i  in  16  flash read data
flash_ce_n / flash_oe_n  out  1 each  flash strobes, active-low

Behaviour:
- Reset (asynchronous, rst=0): state IDLE; bus_ack_o=0; bus_data_o=0; all _n strobes=1; sram_be_n=4'hF; sram_data_oe=0; addresses and sram_data_o=0. Strobes deassert immediately, including when reset arrives mid-access.
- Valid request: bus_ce_i=1 and bus_select_i!=0, sampled only in IDLE. On accept, address, data, we and select are latched internally; later bus changes are ignored until ack.
- Multiple select bits set: priority goes to bit0, then bit1. A request with only unmapped bits set goes straight to ACK with read data 32'h0, no strobes.
- States: IDLE, SRAM_RD, SRAM_WR, FL_LO, FL_HI, ACK, HOLD. A 4-bit wait counter is loaded on each state entry.
- SRAM_RD: ce_n=0, oe_n=0 for SRAM_WAIT cycles. sram_data_i is captured on the last cycle's edge into bus_data_o, then the block enters ACK.
- SRAM_WR: ce_n=0, we_n=0, data_oe=1, data driven for SRAM_WAIT cycles. In ACK, we_n=1 and ce_n=1, but address, data and oe are held one more cycle for hold time.
- Flash read: FL_LO uses flash_addr_o={bus_addr_i[22:2],1'b0}. FL_HI uses the same address with LSB=1. Each phase holds ce_n=0, oe_n=0 for FLASH_WAIT cycles. LO data goes to bus_data_o[15:0], HI data to [31:16]. flash_ce_n returns high for one cycle between the two phases.
- Flash write: ignored. No strobes; go to ACK; bus_data_o is unchanged.
- ACK: bus_ack_o=1 for exactly one cycle, then HOLD.
- HOLD: one mandatory dead cycle, then IDLE. Any request seen in HOLD is ignored. This exists because the MMU still presents the completed request for one cycle after ack and must not be re-executed.
- bus_data_o changes only on read completion and holds its value until the next read.
- Latency, measured from the accepting edge to the bus_ack_o=1 cycle:
  - SRAM read/write: SRAM_WAIT+1 cycles.
  - Flash read: 2*FLASH_WAIT+2 cycles (includes the gap cycle).
  - Unmapped or flash write: 1 cycle.
  - Minimum spacing between two accepts: latency+2 cycles.
- bus_ce_i dropping mid-transaction does not abort it: the access completes and ack still pulses.
- Counter has no wrap-around: SRAM_WAIT and FLASH_WAIT must be nonzero; 0 is illegal and is checked by a simulation assertion.

Test Plan:
- SRAM read, SRAM_WAIT=2, addr 32'h0000_0010, sram_data_i=32'hDEADBEEF -> sram_addr_o=20'h4, oe_n low for 2 cycles, ack on the 3rd cycle after accept, bus_data_o=32'hDEADBEEF.
- SRAM write, addr 32'h0000_0100, data 32'h12345678 -> we_n low exactly 2 cycles, data_oe=1 through the ACK cycle, sram_addr_o=20'h40, be_n=0000, one ack pulse.
- Flash read, FLASH_WAIT=4, addr 32'h0000_0008, halfwords 16'hBEEF then 16'hCAFE -> flash_addr_o 23'h4 then 23'h5, ce_n gap of one cycle, ack at cycle 10, bus_data_o=32'hCAFEBEEF.
- Request held for 3 cycles after ack (MMU behaviour), select=16'h0001 -> exactly one SRAM access and one ack; a second, new request is accepted only after HOLD.
- Unmapped select 16'h0004 read -> ack 1 cycle after accept, bus_data_o=0, no strobe toggles. Select 16'h0003 -> SRAM access only.
- rst pulled low during cycle 1 of an SRAM write -> we_n, ce_n high and data_oe=0 asynchronously, bus_ack_o never pulses. After release, state is IDLE and the next read succeeds.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Physical bus controller: runs one MMU request at a time on the 32-bit async SRAM
// or the 16-bit NOR flash, then pulses ack and inserts one dead cycle.
module mem_bus_ctrl #(
   parameter int SRAM_WAIT  = 2,
   parameter int FLASH_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_ce_i,
   input  logic [31:0] bus_addr_i,
   input  logic [31:0] bus_data_i,
   input  logic        bus_we_i,
   input  logic [15:0] bus_select_i,
   output logic [31:0] bus_data_o,
   output logic        bus_ack_o,
   output logic [19:0] sram_addr_o,
   output logic [31:0] sram_data_o,
   input  logic [31:0] sram_data_i,
   output logic        sram_data_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic [3:0]  sram_be_n,
   output logic [22:0] flash_addr_o,
   input  logic [15:0] flash_data_i,
   output logic        flash_ce_n,
   output logic        flash_oe_n,
   output logic [2:0]  state_o
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SRAM_RD = 3'd1,
      SRAM_WR = 3'd2,
      FL_LO   = 3'd3,
      FL_HI   = 3'd4,
      ACK     = 3'd5,
      HOLD    = 3'd6
   } state_e;

   localparam logic [3:0] SRAM_LOAD = 4'(SRAM_WAIT - 1);
   localparam logic [3:0] FL_LOAD   = 4'(FLASH_WAIT - 1);
   // FL_HI opens with one strobe-free gap cycle, so it counts one extra cycle.
   localparam logic [3:0] FL_GAP    = 4'(FLASH_WAIT);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [15:0] lo_q;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{bus_addr_i[31:23], bus_addr_i[1:0]};
   assign state_o = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'h0;
         lo_q         <= 16'h0;
         bus_ack_o    <= 1'b0;
         bus_data_o   <= 32'h0;
         sram_addr_o  <= 20'h0;
         sram_data_o  <= 32'h0;
         sram_data_oe <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_be_n    <= 4'hF;
         flash_addr_o <= 23'h0;
         flash_ce_n   <= 1'b1;
         flash_oe_n   <= 1'b1;
      end else begin
         bus_ack_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus_ce_i && (bus_select_i != 16'h0)) begin
                  if (bus_select_i[0]) begin
                     sram_addr_o <= bus_addr_i[21:2];
                     sram_ce_n   <= 1'b0;
                     sram_be_n   <= 4'h0;
                     cnt_q       <= SRAM_LOAD;
                     if (bus_we_i) begin
                        sram_data_o  <= bus_data_i;
                        sram_data_oe <= 1'b1;
                        sram_we_n    <= 1'b0;
                        state_q      <= SRAM_WR;
                     end else begin
                        sram_oe_n <= 1'b0;
                        state_q   <= SRAM_RD;
                     end
                  end else if (bus_select_i[1] && !bus_we_i) begin
                     flash_addr_o <= {bus_addr_i[22:2], 1'b0};
                     flash_ce_n   <= 1'b0;
                     flash_oe_n   <= 1'b0;
                     cnt_q        <= FL_LOAD;
                     state_q      <= FL_LO;
                  end else begin
                     // Unmapped read returns zero; flash writes leave read data alone.
                     if (!bus_select_i[1] && !bus_we_i) bus_data_o <= 32'h0;
                     bus_ack_o <= 1'b1;
                     cnt_q     <= 4'h0;
                     state_q   <= ACK;
                  end
               end
            end
            SRAM_RD: begin
               if (cnt_q == 4'h0) begin
                  bus_data_o <= sram_data_i;
                  sram_ce_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
                  sram_be_n  <= 4'hF;
                  bus_ack_o  <= 1'b1;
                  state_q    <= ACK;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            SRAM_WR: begin
               // Address, data and oe stay put through ACK for hold time.
               if (cnt_q == 4'h0) begin
                  sram_ce_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  bus_ack_o <= 1'b1;
                  state_q   <= ACK;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            FL_LO: begin
               if (cnt_q == 4'h0) begin
                  lo_q            <= flash_data_i;
                  flash_ce_n      <= 1'b1;
                  flash_oe_n      <= 1'b1;
                  flash_addr_o[0] <= 1'b1;
                  cnt_q           <= FL_GAP;
                  state_q         <= FL_HI;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            FL_HI: begin
               if (cnt_q == FL_GAP) begin
                  flash_ce_n <= 1'b0;
                  flash_oe_n <= 1'b0;
                  cnt_q      <= cnt_q - 4'h1;
               end else if (cnt_q == 4'h0) begin
                  bus_data_o <= {flash_data_i, lo_q};
                  flash_ce_n <= 1'b1;
                  flash_oe_n <= 1'b1;
                  bus_ack_o  <= 1'b1;
                  state_q    <= ACK;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            ACK: begin
               sram_data_oe <= 1'b0;
               sram_be_n    <= 4'hF;
               cnt_q        <= 4'h0;
               state_q      <= HOLD;
            end
            HOLD: begin
               cnt_q   <= 4'h0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The wait counter has no wrap-around, so zero wait states cannot work.
   param_legal_a: assert property (@(posedge clk)
      (SRAM_WAIT >= 1) && (SRAM_WAIT <= 15) && (FLASH_WAIT >= 1) && (FLASH_WAIT <= 15));

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: SRAM read/write, flash read, held request,
// unmapped/priority selects, flash write and asynchronous reset mid-access.
module tb_mem_bus_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        bus_ce_i;
   logic [31:0] bus_addr_i;
   logic [31:0] bus_data_i;
   logic        bus_we_i;
   logic [15:0] bus_select_i;
   logic [31:0] bus_data_o;
   logic        bus_ack_o;
   logic [19:0] sram_addr_o;
   logic [31:0] sram_data_o;
   logic [31:0] sram_data_i;
   logic        sram_data_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [3:0]  sram_be_n;
   logic [22:0] flash_addr_o;
   logic [15:0] flash_data_i;
   logic        flash_ce_n;
   logic        flash_oe_n;
   logic [2:0]  state_o;

   int checks   = 0;
   int failures = 0;

   // Per-cycle activity counters, sampled at the end of each cycle.
   int ack_cnt = 0, sce_cnt = 0, soe_cnt = 0, swe_cnt = 0, fce_cnt = 0;
   int ack0, sce0, soe0, swe0, fce0;

   mem_bus_ctrl #(.SRAM_WAIT(2), .FLASH_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .bus_ce_i(bus_ce_i), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
      .bus_we_i(bus_we_i), .bus_select_i(bus_select_i),
      .bus_data_o(bus_data_o), .bus_ack_o(bus_ack_o),
      .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
      .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
      .flash_addr_o(flash_addr_o), .flash_data_i(flash_data_i),
      .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_ack_o)   ack_cnt++;
      if (!sram_ce_n)  sce_cnt++;
      if (!sram_oe_n)  soe_cnt++;
      if (!sram_we_n)  swe_cnt++;
      if (!flash_ce_n) fce_cnt++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [15:0] sel, input logic we,
                      input logic [31:0] addr, input logic [31:0] data);
      bus_ce_i     = 1'b1;
      bus_select_i = sel;
      bus_we_i     = we;
      bus_addr_i   = addr;
      bus_data_i   = data;
      ack0 = ack_cnt; sce0 = sce_cnt; soe0 = soe_cnt; swe0 = swe_cnt; fce0 = fce_cnt;
   endtask

   initial begin
      rst = 1'b0;
      bus_ce_i = 1'b0; bus_addr_i = '0; bus_data_i = '0; bus_we_i = 1'b0;
      bus_select_i = '0; sram_data_i = '0; flash_data_i = '0;
      tick(2);
      chk("rst_ack", bus_ack_o, 0);
      chk("rst_data", bus_data_o, 0);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, flash_ce_n, flash_oe_n}, 5'h1F);
      chk("rst_be", sram_be_n, 4'hF);
      chk("rst_oe", sram_data_oe, 0);
      chk("rst_addr", {sram_addr_o, flash_addr_o}, 0);
      chk("rst_sdata", sram_data_o, 0);
      chk("rst_state", state_o, 0);
      rst = 1'b1;
      tick(1);

      // SRAM read
      sram_data_i = 32'hDEADBEEF;
      req(16'h0001, 1'b0, 32'h0000_0010, 32'h0);
      tick(1);
      chk("srd_addr", sram_addr_o, 20'h4);
      chk("srd_c1_strb", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001);
      chk("srd_c1_be", sram_be_n, 4'h0);
      chk("srd_c1_ack", bus_ack_o, 0);
      bus_ce_i = 1'b0;
      tick(1);
      chk("srd_c2_oe", sram_oe_n, 0);
      chk("srd_c2_ack", bus_ack_o, 0);
      tick(1);
      chk("srd_c3_ack", bus_ack_o, 1);
      chk("srd_c3_oe", sram_oe_n, 1);
      chk("srd_data", bus_data_o, 32'hDEADBEEF);
      tick(1);
      chk("srd_c4_ack", bus_ack_o, 0);
      chk("srd_c4_state", state_o, 6);
      tick(1);
      chk("srd_idle", state_o, 0);
      chk("srd_acks", ack_cnt - ack0, 1);
      chk("srd_oe_cycles", soe_cnt - soe0, 2);

      // SRAM write
      req(16'h0001, 1'b1, 32'h0000_0100, 32'h12345678);
      tick(1);
      chk("swr_c1_strb", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b010);
      chk("swr_c1_oe", sram_data_oe, 1);
      chk("swr_addr", sram_addr_o, 20'h40);
      chk("swr_wdata", sram_data_o, 32'h12345678);
      chk("swr_be", sram_be_n, 4'h0);
      bus_ce_i = 1'b0;
      tick(2);
      chk("swr_c3_ack", bus_ack_o, 1);
      chk("swr_c3_strb", {sram_ce_n, sram_we_n}, 2'b11);
      chk("swr_c3_hold", {sram_data_oe, sram_addr_o, sram_data_o}, {1'b1, 20'h40, 32'h12345678});
      tick(1);
      chk("swr_c4_oe", sram_data_oe, 0);
      tick(1);
      chk("swr_we_cycles", swe_cnt - swe0, 2);
      chk("swr_acks", ack_cnt - ack0, 1);
      chk("swr_rdata_kept", bus_data_o, 32'hDEADBEEF);

      // Flash read
      flash_data_i = 16'hBEEF;
      req(16'h0002, 1'b0, 32'h0000_0008, 32'h0);
      tick(1);
      chk("fl_lo_addr", flash_addr_o, 23'h4);
      chk("fl_lo_strb", {flash_ce_n, flash_oe_n}, 2'b00);
      bus_ce_i = 1'b0;
      tick(3);
      chk("fl_c4_ce", flash_ce_n, 0);
      tick(1);
      chk("fl_gap_strb", {flash_ce_n, flash_oe_n}, 2'b11);
      chk("fl_hi_addr", flash_addr_o, 23'h5);
      chk("fl_gap_data", bus_data_o, 32'hDEADBEEF);
      flash_data_i = 16'hCAFE;
      tick(1);
      chk("fl_c6_ce", flash_ce_n, 0);
      tick(3);
      chk("fl_c9_ack", bus_ack_o, 0);
      tick(1);
      chk("fl_c10_ack", bus_ack_o, 1);
      chk("fl_data", bus_data_o, 32'hCAFEBEEF);
      tick(2);
      chk("fl_ce_cycles", fce_cnt - fce0, 8);
      chk("fl_acks", ack_cnt - ack0, 1);

      // Request held past ack, then a new request right after HOLD
      sram_data_i = 32'hA5A50001;
      req(16'h0001, 1'b0, 32'h0000_0020, 32'h0);
      tick(3);
      chk("held_ack", bus_ack_o, 1);
      chk("held_data", bus_data_o, 32'hA5A50001);
      tick(1);
      chk("held_hold", state_o, 6);
      bus_addr_i = 32'h0000_0024;
      sram_data_i = 32'h5A5A0002;
      tick(1);
      chk("held_idle", state_o, 0);
      chk("held_oe_n", sram_oe_n, 1);
      chk("held_acks", ack_cnt - ack0, 1);
      chk("held_oe_cycles", soe_cnt - soe0, 2);
      tick(1);
      chk("next_state", state_o, 1);
      chk("next_addr", sram_addr_o, 20'h9);
      bus_ce_i = 1'b0;
      tick(2);
      chk("next_ack", bus_ack_o, 1);
      chk("next_data", bus_data_o, 32'h5A5A0002);
      tick(2);

      // Unmapped select
      req(16'h0004, 1'b0, 32'h0000_0040, 32'h0);
      tick(1);
      chk("unm_ack", bus_ack_o, 1);
      chk("unm_data", bus_data_o, 0);
      bus_ce_i = 1'b0;
      tick(2);
      chk("unm_idle", state_o, 0);
      chk("unm_strobes", (sce_cnt - sce0) + (fce_cnt - fce0), 0);
      chk("unm_acks", ack_cnt - ack0, 1);

      // Both SRAM and flash selected: SRAM wins
      sram_data_i = 32'h33330003;
      req(16'h0003, 1'b0, 32'h0000_0030, 32'h0);
      tick(1);
      chk("pri_sce", sram_ce_n, 0);
      chk("pri_fce", flash_ce_n, 1);
      chk("pri_addr", sram_addr_o, 20'hC);
      bus_ce_i = 1'b0;
      tick(2);
      chk("pri_ack", bus_ack_o, 1);
      chk("pri_data", bus_data_o, 32'h33330003);
      tick(2);
      chk("pri_fl_cycles", fce_cnt - fce0, 0);

      // Flash write is ignored
      req(16'h0002, 1'b1, 32'h0000_0050, 32'h00000099);
      tick(1);
      chk("fwr_ack", bus_ack_o, 1);
      chk("fwr_data", bus_data_o, 32'h33330003);
      bus_ce_i = 1'b0;
      tick(2);
      chk("fwr_fl_cycles", fce_cnt - fce0, 0);

      // Asynchronous reset during cycle 1 of an SRAM write
      req(16'h0001, 1'b1, 32'h0000_0200, 32'hFEEDF00D);
      tick(1);
      chk("rw_we_low", sram_we_n, 0);
      #2 rst = 1'b0;
      #1;
      chk("rw_strb", {sram_we_n, sram_ce_n}, 2'b11);
      chk("rw_oe", sram_data_oe, 0);
      chk("rw_state", state_o, 0);
      bus_ce_i = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(4);
      chk("rw_no_ack", ack_cnt - ack0, 0);
      sram_data_i = 32'h0BADCAFE;
      req(16'h0001, 1'b0, 32'h0000_0008, 32'h0);
      tick(1);
      bus_ce_i = 1'b0;
      tick(2);
      chk("rw_after_ack", bus_ack_o, 1);
      chk("rw_after_data", bus_data_o, 32'h0BADCAFE);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
